calc_datapath: RTL

Operand/result datapath directly downstream of the calculator's keypress-sequencing control unit. It consumes that unit's active-low load strobes and clear to capture operands A and B from the switch bank. It computes add/sub/mul/div on request (multi-cycle for mul/div) and drives a registered display word.

---
 rtl/calc_pkg.sv | 18 +
 rtl/calc_datapath_if.sv | 28 ++
 rtl/shift_muldiv.sv | 70 +++++++
 rtl/calc_datapath.sv | 123 ++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand/result datapath.
package calc_pkg;

    localparam int unsigned CALC_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } calc_state_t;

endpackage

// File: rtl/calc_datapath_if.sv
// Bus between the keypress-sequencing control unit (master) and the datapath (slave).
interface calc_datapath_if #(
    parameter int unsigned W = calc_pkg::CALC_W
);
    logic [W-1:0]   sw;
    logic [1:0]     op;
    logic           clear_n;
    logic           load_a_n;
    logic           load_b_n;
    logic           load_r_n;
    logic           sel_result;
    logic [2*W-1:0] disp;
    logic [2*W-1:0] result;
    logic           busy;
    logic           done;
    logic           ovf;
    logic           dbz;

    modport master (
        output sw, op, clear_n, load_a_n, load_b_n, load_r_n, sel_result,
        input  disp, result, busy, done, ovf, dbz
    );

    modport slave (
        input  sw, op, clear_n, load_a_n, load_b_n, load_r_n, sel_result,
        output disp, result, busy, done, ovf, dbz
    );
endinterface

// File: rtl/shift_muldiv.sv
// W-step iterative unit: shift-add multiplier or restoring divider, one step per cycle.
// res is the value the accumulator takes on this step; on the last step it is the final result.
module shift_muldiv
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           last,
    output logic [2*W-1:0] res
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] acc;
    logic [W-1:0]   opnd;
    logic           div_mode;
    logic           running;
    logic [CW-1:0]  count;

    logic [W:0]     mul_sum;
    logic [W:0]     mul_hi;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_trial;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;

    // MUL: acc = {partial product, remaining multiplier bits}; DIV: acc = {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
        mul_hi    = acc[0] ? mul_sum : {1'b0, acc[2*W-1:W]};
        mul_next  = {mul_hi, acc[W-1:1]};
        div_trial = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_trial - {1'b0, opnd};
        if (div_trial >= {1'b0, opnd}) begin
            div_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        end else begin
            div_next = {div_trial[W-1:0], acc[W-2:0], 1'b0};
        end
        res  = div_mode ? div_next : mul_next;
        last = running && (count == CW'(W - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            running  <= 1'b0;
            count    <= '0;
        end else if (start) begin
            acc      <= {{W{1'b0}}, a};
            opnd     <= b;
            div_mode <= is_div;
            running  <= 1'b1;
            count    <= '0;
        end else if (running) begin
            acc   <= res;
            count <= count + 1'b1;
            if (last) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_datapath.sv
// Calculator operand/result datapath: A/B capture, add/sub in one cycle, mul/div over W cycles,
// registered display word.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
) (
    input  logic             clock,
    input  logic             reset,
    calc_datapath_if.slave   bus
);
    calc_state_t    state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] r_q;
    logic [2*W-1:0] disp_q;
    logic           busy_q;
    logic           done_q;
    logic           ovf_q;
    logic           dbz_q;
    logic           prev_q;

    logic           clr;
    logic           start;
    logic           md_start;
    calc_op_t       op_sel;
    logic [W:0]     sum;
    logic [W:0]     diff;
    logic           md_last;
    logic [2*W-1:0] md_res;

    always_comb begin
        clr      = reset | ~bus.clear_n;
        op_sel   = calc_op_t'(bus.op);
        start    = prev_q & ~bus.load_r_n & ~busy_q;
        md_start = start && ((op_sel == OP_MUL) || ((op_sel == OP_DIV) && (b_q != '0)));
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
    end

    shift_muldiv #(
        .W (W)
    ) u_muldiv (
        .clock  (clock),
        .reset  (clr),
        .start  (md_start),
        .is_div (op_sel == OP_DIV),
        .a      (a_q),
        .b      (b_q),
        .last   (md_last),
        .res    (md_res)
    );

    always_ff @(posedge clock) begin
        if (clr) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            disp_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
            prev_q <= 1'b1;
        end else begin
            prev_q <= bus.load_r_n;
            done_q <= 1'b0;
            disp_q <= bus.sel_result ? r_q : {b_q, a_q};
            if (!busy_q) begin
                if (!bus.load_a_n) a_q <= bus.sw;
                if (!bus.load_b_n) b_q <= bus.sw;
            end
            case (state)
                IDLE: begin
                    if (md_start) begin
                        state  <= ITER;
                        busy_q <= 1'b1;
                    end else if (start) begin
                        done_q <= 1'b1;
                        case (op_sel)
                            OP_ADD: begin
                                r_q   <= {{(W-1){1'b0}}, sum};
                                ovf_q <= sum[W];
                                dbz_q <= 1'b0;
                            end
                            OP_SUB: begin
                                r_q   <= {{(W-1){diff[W]}}, diff};
                                ovf_q <= diff[W];
                                dbz_q <= 1'b0;
                            end
                            default: begin
                                // only divide-by-zero reaches here; MUL and DIV(B!=0) take md_start
                                r_q   <= '1;
                                ovf_q <= 1'b0;
                                dbz_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ITER: begin
                    if (md_last) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        r_q    <= md_res;
                        ovf_q  <= 1'b0;
                        dbz_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.disp   = disp_q;
    assign bus.result = r_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ovf    = ovf_q;
    assign bus.dbz    = dbz_q;

endmodule
